sprite_draw_ctrl: RTL and testbench

- Raster-sweep sequencer that sits directly upstream of the x/y coordinate registers, the colour mux and the VGA adapter.
- On a start request it captures a drawing origin and an image-source select, then sweeps every pixel of a box one pixel per clock.
- For each pixel it drives screen coordinates, a plot strobe and a linear image-memory address.
- Used for full-screen title/choose/win images and for fixed-size character sprites at battle positions.

---
 rtl/sprite_draw_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sprite_draw_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_ctrl.sv
// Raster-sweep draw sequencer: on start it captures a box origin and image source,
// then walks the box one pixel per clock, producing coordinates, a plot strobe and an image address.
module sprite_draw_ctrl #(
    parameter int SPR_W = 40,
    parameter int SPR_H = 40,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        fullScreen,
    input  logic [7:0]  xOrigin,
    input  logic [6:0]  yOrigin,
    input  logic [4:0]  memSelIn,
    input  logic        blackIn,
    output logic        busy,
    output logic        done,
    output logic        plot,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [14:0] addr,
    output logic [4:0]  memorySel,
    output logic        black
);

    localparam logic [7:0] SPR_W_BOX = 8'(SPR_W);
    localparam logic [6:0] SPR_H_BOX = 7'(SPR_H);
    localparam logic [7:0] SCR_W_BOX = 8'(SCR_W);
    localparam logic [6:0] SCR_H_BOX = 7'(SCR_H);
    localparam logic [8:0] SCR_W_LIM = 9'(SCR_W);
    localparam logic [7:0] SCR_H_LIM = 8'(SCR_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [7:0]  ox_r;
    logic [6:0]  oy_r;
    logic        full_r;
    logic [7:0]  cx_r;
    logic [6:0]  cy_r;
    logic        plot_r;

    logic [7:0]  box_w_s;
    logic [6:0]  box_h_s;
    logic        last_col_s;
    logic        last_row_s;
    logic [7:0]  next_cx_s;
    logic [6:0]  next_cy_s;
    logic [8:0]  x_sum_s;
    logic [7:0]  y_sum_s;

    // Sums are one bit wider than the ports so an origin+offset overflow clips instead of wrapping.
    function automatic logic on_screen(input logic [8:0] xs, input logic [7:0] ys);
        return (xs < SCR_W_LIM) && (ys < SCR_H_LIM);
    endfunction

    // Box size, raster-order step, and the screen position of the next pixel.
    always_comb begin
        box_w_s    = SPR_W_BOX;
        box_h_s    = SPR_H_BOX;
        next_cx_s  = 8'd0;
        next_cy_s  = 7'd0;
        if (full_r) begin
            box_w_s = SCR_W_BOX;
            box_h_s = SCR_H_BOX;
        end else begin
            box_w_s = SPR_W_BOX;
            box_h_s = SPR_H_BOX;
        end
        last_col_s = (cx_r == (box_w_s - 8'd1));
        last_row_s = (cy_r == (box_h_s - 7'd1));
        if (state_r == LOAD) begin
            next_cx_s = 8'd0;
            next_cy_s = 7'd0;
        end else if (last_col_s) begin
            next_cx_s = 8'd0;
            next_cy_s = cy_r + 7'd1;
        end else begin
            next_cx_s = cx_r + 8'd1;
            next_cy_s = cy_r;
        end
        x_sum_s = {1'b0, ox_r} + {1'b0, next_cx_s};
        y_sum_s = {1'b0, oy_r} + {1'b0, next_cy_s};
    end

    // Sequencer state, captured draw parameters and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            ox_r      <= 8'd0;
            oy_r      <= 7'd0;
            full_r    <= 1'b0;
            cx_r      <= 8'd0;
            cy_r      <= 7'd0;
            plot_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x         <= 8'd0;
            y         <= 7'd0;
            addr      <= 15'd0;
            memorySel <= 5'd0;
            black     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ox_r      <= fullScreen ? 8'd0 : xOrigin;
                        oy_r      <= fullScreen ? 7'd0 : yOrigin;
                        full_r    <= fullScreen;
                        memorySel <= memSelIn;
                        black     <= blackIn;
                        busy      <= 1'b1;
                        state_r   <= LOAD;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                LOAD: begin
                    cx_r    <= next_cx_s;
                    cy_r    <= next_cy_s;
                    x       <= x_sum_s[7:0];
                    y       <= y_sum_s[6:0];
                    addr    <= 15'd0;
                    plot_r  <= on_screen(x_sum_s, y_sum_s);
                    state_r <= DRAW;
                end
                DRAW: begin
                    if (last_col_s && last_row_s) begin
                        plot_r  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        // Clipped pixels still advance the address so image rows stay aligned.
                        cx_r    <= next_cx_s;
                        cy_r    <= next_cy_s;
                        x       <= x_sum_s[7:0];
                        y       <= y_sum_s[6:0];
                        addr    <= addr + 15'd1;
                        plot_r  <= on_screen(x_sum_s, y_sum_s);
                        state_r <= DRAW;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    plot_r  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Reset suppresses the pixel strobe in the same cycle it is asserted.
    assign plot = plot_r & ~reset;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Directed, table-driven bench for sprite_draw_ctrl with a per-pixel raster reference.
module tb_sprite_draw_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        fullScreen;
    logic [7:0]  xOrigin;
    logic [6:0]  yOrigin;
    logic [4:0]  memSelIn;
    logic        blackIn;
    logic        busy;
    logic        done;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] addr;
    logic [4:0]  memorySel;
    logic        black;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int full; int xo; int yo; int ms; int blk;
        int fx; int fy; int lx; int ly; int la;
        int plots; int done_c;
    } vec_t;

    vec_t tbl[6];

    sprite_draw_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .fullScreen(fullScreen),
        .xOrigin(xOrigin), .yOrigin(yOrigin), .memSelIn(memSelIn), .blackIn(blackIn),
        .busy(busy), .done(done), .plot(plot), .x(x), .y(y), .addr(addr),
        .memorySel(memorySel), .black(black)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply a start request, then scramble the inputs to prove they were captured.
    task automatic pulse_start(input vec_t v);
        fullScreen = v.full[0];
        xOrigin    = 8'(v.xo);
        yOrigin    = 7'(v.yo);
        memSelIn   = 5'(v.ms);
        blackIn    = v.blk[0];
        start      = 1'b1;
        step();
        start      = 1'b0;
        fullScreen = ~v.full[0];
        xOrigin    = 8'(v.xo + 33);
        yOrigin    = 7'(v.yo + 17);
        memSelIn   = ~5'(v.ms);
        blackIn    = ~v.blk[0];
    endtask

    task automatic run_vec(input int id, input vec_t v, input int glitch_c);
        int w, h, wh, xe, ye, plots, done_c, done_n, pix_err, first_bad;
        int fx, fy, fa, lx, ly, la;
        w  = v.full ? 160 : 40;
        h  = v.full ? 120 : 40;
        wh = w * h;
        xe = v.full ? 0 : v.xo;
        ye = v.full ? 0 : v.yo;
        plots = 0; done_c = 0; done_n = 0; pix_err = 0; first_bad = 0;
        fx = -1; fy = -1; fa = -1; lx = -1; ly = -1; la = -1;
        pulse_start(v);
        chk($sformatf("v%0d_load_busy", id), int'(busy), 1);
        chk($sformatf("v%0d_load_plot", id), int'(plot), 0);
        for (int c = 2; c <= wh + 6; c++) begin
            start = (c == glitch_c) ? 1'b1 : 1'b0;
            step();
            if (plot) plots++;
            if (done) begin
                done_n++;
                if (done_c == 0) done_c = c;
            end
            if (c == 2) begin fx = int'(x); fy = int'(y); fa = int'(addr); end
            if (c == wh + 1) begin lx = int'(x); ly = int'(y); la = int'(addr); end
            if (c <= wh + 1) begin
                int idx, cx, cy, ex, ey, ep;
                idx = c - 2;
                cx  = idx % w;
                cy  = idx / w;
                ex  = (xe + cx) % 256;
                ey  = (ye + cy) % 128;
                ep  = ((xe + cx) < 160 && (ye + cy) < 120) ? 1 : 0;
                if (int'(x) != ex || int'(y) != ey || int'(addr) != idx || int'(plot) != ep ||
                    busy !== 1'b1 || done !== 1'b0 || int'(memorySel) != v.ms || int'(black) != v.blk) begin
                    if (pix_err == 0) first_bad = c;
                    pix_err++;
                end
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d_pixel_seq_bad_cycles(first c=%0d)", id, first_bad), pix_err, 0);
        chk($sformatf("v%0d_first_x", id), fx, v.fx);
        chk($sformatf("v%0d_first_y", id), fy, v.fy);
        chk($sformatf("v%0d_first_addr", id), fa, 0);
        chk($sformatf("v%0d_last_x", id), lx, v.lx);
        chk($sformatf("v%0d_last_y", id), ly, v.ly);
        chk($sformatf("v%0d_last_addr", id), la, v.la);
        chk($sformatf("v%0d_plot_count", id), plots, v.plots);
        chk($sformatf("v%0d_done_cycle", id), done_c, v.done_c);
        chk($sformatf("v%0d_done_count", id), done_n, 1);
        chk($sformatf("v%0d_idle_busy", id), int'(busy), 0);
        chk($sformatf("v%0d_held_memsel", id), int'(memorySel), v.ms);
        chk($sformatf("v%0d_held_black", id), int'(black), v.blk);
    endtask

    initial begin
        int dn, pn, bn;
        vec_t vr;
        vec_t vn;
        tbl[0] = '{0,  90,  30, 10, 0,  90,  30, 129,  69,  1599,  1600,  1602};
        tbl[1] = '{1,  50,  20,  3, 0,   0,   0, 159, 119, 19199, 19200, 19202};
        tbl[2] = '{0, 140, 100, 21, 0, 140, 100, 179,  11,  1599,   400,  1602};
        tbl[3] = '{0, 159, 119,  7, 0, 159, 119, 198,  30,  1599,     1,  1602};
        tbl[4] = '{0, 250,   0, 12, 0, 250,   0,  33,  39,  1599,     0,  1602};
        tbl[5] = '{0,   0,   0, 31, 1,   0,   0,  39,  39,  1599,  1600,  1602};
        vr     = '{0,  20,  10,  9, 1,  20,  10,  59,  49,  1599,  1600,  1602};
        vn     = '{0,  10,   5, 17, 0,  10,   5,  49,  44,  1599,  1600,  1602};

        reset = 1'b1; start = 1'b0; fullScreen = 1'b0; xOrigin = 8'd0;
        yOrigin = 7'd0; memSelIn = 5'd0; blackIn = 1'b0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_memsel", int'(memorySel), 0);
        chk("rst_black", int'(black), 0);
        reset = 1'b0;
        dn = 0; pn = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) dn++;
            if (plot) pn++;
        end
        chk("idle_done_count", dn, 0);
        chk("idle_plot_count", pn, 0);

        // Table vectors; the first one also gets a stray start mid-draw.
        for (int i = 0; i < 6; i++) begin
            run_vec(i, tbl[i], (i == 0) ? 100 : 0);
        end

        // Reset in the middle of a draw: no done pulse, outputs back to reset values.
        pulse_start(vr);
        for (int c = 2; c <= 502; c++) step();
        chk("mid_addr", int'(addr), 500);
        chk("mid_x", int'(x), 40);
        chk("mid_y", int'(y), 22);
        reset = 1'b1;
        step();
        chk("mrst_plot", int'(plot), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_addr", int'(addr), 0);
        chk("mrst_x", int'(x), 0);
        chk("mrst_memsel", int'(memorySel), 0);
        chk("mrst_black", int'(black), 0);
        reset = 1'b0;
        dn = 0; bn = 0; pn = 0;
        for (int i = 0; i < 1700; i++) begin
            step();
            if (done) dn++;
            if (busy) bn++;
            if (plot) pn++;
        end
        chk("mrst_no_done", dn, 0);
        chk("mrst_no_busy", bn, 0);
        chk("mrst_no_plot", pn, 0);
        run_vec(6, vn, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
